// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
// Holds request size codes, FSM state encoding, lane geometry constants and a
// helper that maps a size code to its access width in bytes.
package mem_pkg;

    // Request size codes (req_size)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

    // Lane geometry of the 32-bit RAM word
    localparam int unsigned LANES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 8;

    // Access width in bytes; the reserved code is rejected before this matters.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction and extension.
// Ports:
//   word_i     - full 32-bit word read from RAM
//   addr_lo_i  - byte offset addr[1:0] within the word
//   size_i     - size code (byte/half/word)
//   unsigned_i - 1: zero-extend sub-word loads, 0: sign-extend
//   result_o   - right-aligned, extended load result
// Halfword selection uses addr[1] only, so a half at an odd address is
// aligned down.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: result_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: result_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port 32-bit RAM.
// Accepts one request at a time, performs a read, write, or read-modify-write
// of the addressed word, and returns a one-cycle response pulse.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   req_*             - request handshake and fields (latched on accept)
//   rsp_valid/rdata/err - one-cycle response, zero outside the response cycle
//   mem_*             - RAM side; mem_rdata is combinational, writes are full-word
// Configuration macro: MISALIGN_EXC_EN - when defined, misaligned half/word
// requests are rejected with rsp_err; otherwise they are aligned down.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [32:0] end_addr;
    logic        range_err;
    logic        misalign_err;
    logic        req_bad;
    logic [31:0] merged;
    logic [31:0] load_res;

    // 33-bit sum so an address near 2^32 cannot wrap past the range check
    assign end_addr  = {1'b0, req_addr} + {30'h0, size_bytes(req_size)};
    assign range_err = end_addr > 33'(MEM_BYTES);

`ifdef MISALIGN_EXC_EN
    assign misalign_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    assign req_bad = (req_size == SZ_RSVD) || range_err || misalign_err;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    err_d      = req_bad;
                    if (req_bad) begin
                        state_d = ST_RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        // Loads and sub-word stores both need the current word
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = mem_rdata;
                state_d = we_q ? ST_WR : ST_RESP;
            end
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-modify-write merge: only the addressed lane(s) take the store data
    always_comb begin
        merged = rdata_q;
        case (size_q)
            SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    load_align u_load_align (
        .word_i     (rdata_q),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .result_o   (load_res)
    );

    // All outputs decode from the state register so reset clears them at once
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) && err_q;
        rsp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? load_res : 32'h0;
        mem_re    = (state_q == ST_RD);
        mem_we    = (state_q == ST_WR);
        mem_addr  = (mem_re || mem_we) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata = mem_we ? merged : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule
